ac_motor_gate_guard: RTL

- Output stage directly downstream of the three ac_motor_switch_delay instances.
- Takes the six dead-time-separated gate requests (s1_high/s1_low … s3_high/s3_low) and produces the registered gate-driver outputs.
- Adds bootstrap precharge at start-up, shoot-through detection, and filtered overcurrent shutdown.
- Latches a fault code and holds all gates off until the fault is cleared.

---
 rtl/ac_motor_gate_guard_pkg.sv | 28 ++
 rtl/ac_motor_fault_filter.sv | 42 ++++
 rtl/ac_motor_gate_guard.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ac_motor_gate_guard_pkg.sv
// Shared state encoding and fault-cause codes for the three-phase gate output guard.
package ac_motor_gate_guard_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_PRECHARGE = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    localparam logic [2:0] FC_NONE = 3'b000;
    localparam logic [2:0] FC_LEG1 = 3'b001;
    localparam logic [2:0] FC_LEG2 = 3'b010;
    localparam logic [2:0] FC_LEG3 = 3'b011;
    localparam logic [2:0] FC_OVC  = 3'b100;

    // shoot[0] is leg 1; overcurrent outranks every leg, lower leg numbers outrank higher.
    function automatic logic [2:0] fault_cause(input logic ovc, input logic [2:0] shoot);
        logic [2:0] code;
        code = FC_NONE;
        if (ovc)           code = FC_OVC;
        else if (shoot[0]) code = FC_LEG1;
        else if (shoot[1]) code = FC_LEG2;
        else if (shoot[2]) code = FC_LEG3;
        return code;
    endfunction

endpackage

// File: rtl/ac_motor_fault_filter.sv
// Two-flop synchroniser for the overcurrent comparator followed by a saturating
// run-length counter; ovc_trip asserts once FAULT_FILT consecutive high samples are seen.
module ac_motor_fault_filter #(
    parameter int FAULT_FILT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic fault_in,
    output logic fault_s,
    output logic ovc_trip
);
    localparam int CW = $clog2(FAULT_FILT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FAULT_FILT);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (sync2_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= fault_in;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign fault_s  = sync2_q;
    assign ovc_trip = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ac_motor_gate_guard.sv
// Gate-driver output stage: bootstrap precharge, shoot-through and overcurrent
// protection with a latched fault code; all gate outputs are registered.
module ac_motor_gate_guard
    import ac_motor_gate_guard_pkg::*;
#(
    parameter int PRECHARGE_CYCLES = 1000,
    parameter int FAULT_FILT       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       fault_in,
    input  logic       s1_high,
    input  logic       s1_low,
    input  logic       s2_high,
    input  logic       s2_low,
    input  logic       s3_high,
    input  logic       s3_low,
    output logic       g1_high,
    output logic       g1_low,
    output logic       g2_high,
    output logic       g2_low,
    output logic       g3_high,
    output logic       g3_low,
    output logic       running,
    output logic       fault,
    output logic [2:0] fault_code
);
    localparam int PW = $clog2(PRECHARGE_CYCLES + 1);
    localparam logic [PW-1:0] PC_LAST   = PW'(PRECHARGE_CYCLES - 1);
    localparam logic [5:0]    LOW_SIDES = 6'b010101;

    state_t        state_q;
    logic [PW-1:0] pc_q;
    logic [5:0]    gate_q;
    logic          running_q;
    logic          fault_q;
    logic [2:0]    code_q;

    logic [5:0] req;
    logic [2:0] shoot;
    logic       fault_s;
    logic       ovc_trip;

    // Bit order {h1,l1,h2,l2,h3,l3}: leg n occupies bits 5-2n..4-2n.
    assign req = {s1_high, s1_low, s2_high, s2_low, s3_high, s3_low};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_shoot
            assign shoot[gi] = req[2*(2-gi)+1] & req[2*(2-gi)];
        end
    endgenerate

    ac_motor_fault_filter #(
        .FAULT_FILT(FAULT_FILT)
    ) u_fault_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .fault_in(fault_in),
        .fault_s (fault_s),
        .ovc_trip(ovc_trip)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_OFF;
            pc_q      <= '0;
            gate_q    <= '0;
            running_q <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= FC_NONE;
        end else if (state_q != ST_FAULT && (ovc_trip || (|shoot))) begin
            // Protection wins over enable/clear and blanks the offending request on this edge.
            state_q   <= ST_FAULT;
            gate_q    <= '0;
            running_q <= 1'b0;
            fault_q   <= 1'b1;
            code_q    <= fault_cause(ovc_trip, shoot);
        end else begin
            case (state_q)
                ST_OFF: begin
                    gate_q    <= '0;
                    running_q <= 1'b0;
                    if (enable) begin
                        state_q <= ST_PRECHARGE;
                        pc_q    <= '0;
                        gate_q  <= LOW_SIDES;
                    end
                end
                ST_PRECHARGE: begin
                    if (!enable) begin
                        state_q <= ST_OFF;
                        gate_q  <= '0;
                    end else if (pc_q == PC_LAST) begin
                        state_q   <= ST_RUN;
                        gate_q    <= req;
                        running_q <= 1'b1;
                    end else begin
                        pc_q   <= pc_q + PW'(1);
                        gate_q <= LOW_SIDES;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_q   <= ST_OFF;
                        gate_q    <= '0;
                        running_q <= 1'b0;
                    end else begin
                        gate_q <= req;
                    end
                end
                ST_FAULT: begin
                    gate_q    <= '0;
                    running_q <= 1'b0;
                    if (clear && !ovc_trip && !fault_s) begin
                        state_q <= ST_OFF;
                        fault_q <= 1'b0;
                        code_q  <= FC_NONE;
                    end
                end
                default: begin
                    state_q   <= ST_OFF;
                    gate_q    <= '0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign {g1_high, g1_low, g2_high, g2_low, g3_high, g3_low} = gate_q;
    assign running    = running_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule
